// File: rtl/q_row_update.sv
// One row of a Q table with a three-stage TD update: DIFF, MUL, WB.
// Define Q_SAT_EN to saturate d, p and the new Q; by default they wrap modulo 2^W.
module q_row_update #(
    parameter int W       = 24,
    parameter int F       = 14,
    parameter int NUM_ACT = 4,
    localparam int AW     = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clr,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [AW-1:0]        upd_act,
    input  logic [W-1:0]         reward,
    input  logic [W-1:0]         gamma_maxq,
    input  logic [W-1:0]         alpha,
    output logic [NUM_ACT*W-1:0] q_flat,
    output logic [W-1:0]         max_q,
    output logic [AW-1:0]        max_idx,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, DIFF, MUL, WB} state_t;

    state_t               state, state_nxt;
    logic                 accept;
    logic [AW-1:0]        act_r;
    logic signed [W-1:0]  reward_r, gmq_r, alpha_r;
    logic signed [W-1:0]  d_r, p_r;
    logic signed [W-1:0]  q [NUM_ACT];
    logic signed [W-1:0]  q_cur;
    logic signed [W+1:0]  d_sum;
    logic signed [2*W-1:0] d_wide, prod, prod_sh, q_sum;
    logic signed [W-1:0]  best_q;
    logic [AW-1:0]        best_idx;

    // Reduce a wide signed result to W bits: clamp or keep the low W bits.
    function automatic logic signed [W-1:0] reduce(input logic signed [2*W-1:0] v);
`ifdef Q_SAT_EN
        if (v[2*W-1:W-1] == '0 || v[2*W-1:W-1] == '1)
            reduce = v[W-1:0];
        else if (v[2*W-1])
            reduce = {1'b1, {(W-1){1'b0}}};
        else
            reduce = {1'b0, {(W-1){1'b1}}};
`else
        reduce = v[W-1:0];
`endif
    endfunction

    assign upd_ready = (state == IDLE) && !clr;
    assign accept    = upd_valid && upd_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DIFF;
            DIFF:    state_nxt = MUL;
            MUL:     state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range indices read as zero and match no entry, so they never write.
    always_comb begin
        q_cur = '0;
        for (int k = 0; k < NUM_ACT; k++)
            if (act_r == AW'(k)) q_cur = q[k];
    end

    assign d_sum   = $signed({{2{reward_r[W-1]}}, reward_r})
                   + $signed({{2{gmq_r[W-1]}}, gmq_r})
                   - $signed({{2{q_cur[W-1]}}, q_cur});
    assign d_wide  = $signed({{(W-2){d_sum[W+1]}}, d_sum});
    assign prod    = $signed({{W{alpha_r[W-1]}}, alpha_r}) * $signed({{W{d_r[W-1]}}, d_r});
    assign prod_sh = prod >>> F;
    assign q_sum   = $signed({{W{q_cur[W-1]}}, q_cur}) + $signed({{W{p_r[W-1]}}, p_r});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            act_r    <= '0;
            reward_r <= '0;
            gmq_r    <= '0;
            alpha_r  <= '0;
        end else if (accept) begin
            act_r    <= upd_act;
            reward_r <= reward;
            gmq_r    <= gamma_maxq;
            alpha_r  <= alpha;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_r  <= '0;
            p_r  <= '0;
            done <= 1'b0;
        end else begin
            if (!clr && state == DIFF) d_r <= reduce(d_wide);
            if (!clr && state == MUL)  p_r <= reduce(prod_sh);
            done <= !clr && (state == WB);
        end
    end

    // NOTE: the Q row is architectural state, so it takes both the async reset and the sync clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NUM_ACT; k++) q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < NUM_ACT; k++) q[k] <= '0;
        end else if (state == WB) begin
            for (int k = 0; k < NUM_ACT; k++)
                if (act_r == AW'(k)) q[k] <= reduce(q_sum);
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_q   = q[0];
        best_idx = '0;
        for (int k = 1; k < NUM_ACT; k++)
            if (q[k] > best_q) begin
                best_q   = q[k];
                best_idx = AW'(k);
            end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            max_q   <= '0;
            max_idx <= '0;
        end else begin
            max_q   <= best_q;
            max_idx <= best_idx;
        end
    end

    for (genvar g = 0; g < NUM_ACT; g++) begin : g_flat
        assign q_flat[g*W +: W] = q[g];
    end

endmodule

// File: tb/tb_q_row_update.sv
// Scoreboard bench for q_row_update: expected rows are queued at accept and compared at done.
module tb_q_row_update;
    localparam int W  = 24;
    localparam int F  = 14;
    localparam int NA = 4;
    localparam int AW = 2;
    typedef logic [NA*W-1:0] row_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic clr = 1'b0, upd_valid = 1'b0, upd_ready, done;
    logic [AW-1:0] upd_act = '0, max_idx;
    logic [W-1:0] reward = '0, gamma_maxq = '0, alpha = '0, max_q;
    row_t q_flat;

    logic b_clr = 1'b0, b_valid = 1'b0, b_ready, b_done;
    logic [1:0] b_act = '0, b_max_idx;
    logic [W-1:0] b_max_q;
    logic [3*W-1:0] b_q_flat;

    int n_pass = 0, n_total = 0;
    row_t exp_q[$];
    longint q_model[NA];

    always #5 CLK = ~CLK;

    q_row_update #(.W(W), .F(F), .NUM_ACT(NA)) dut (
        .CLK(CLK), .RST(RST), .clr(clr), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_act(upd_act), .reward(reward), .gamma_maxq(gamma_maxq), .alpha(alpha),
        .q_flat(q_flat), .max_q(max_q), .max_idx(max_idx), .done(done));

    q_row_update #(.W(W), .F(F), .NUM_ACT(3)) dut_b (
        .CLK(CLK), .RST(RST), .clr(b_clr), .upd_valid(b_valid), .upd_ready(b_ready),
        .upd_act(b_act), .reward(reward), .gamma_maxq(gamma_maxq), .alpha(alpha),
        .q_flat(b_q_flat), .max_q(b_max_q), .max_idx(b_max_idx), .done(b_done));

    function automatic longint red(input longint v);
        longint t;
`ifdef Q_SAT_EN
        longint maxv, minv;
        maxv = (longint'(1) <<< (W-1)) - 1;
        minv = -(longint'(1) <<< (W-1));
        t = v;
        if (t > maxv) t = maxv;
        else if (t < minv) t = minv;
`else
        t = (v <<< (64-W)) >>> (64-W);
`endif
        return t;
    endfunction

    function automatic row_t pack_model();
        row_t r;
        longint v;
        for (int k = 0; k < NA; k++) begin
            v = q_model[k];
            r[k*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    task automatic model_push(input int act, input longint r, input longint g, input longint a);
        longint q, d, p;
        q = q_model[act];
        d = red(r + g - q);
        p = red((a * d) >>> F);
        q_model[act] = red(q + p);
        exp_q.push_back(pack_model());
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int act, input longint r, input longint g, input longint a);
        upd_act    = AW'(act);
        reward     = r[W-1:0];
        gamma_maxq = g[W-1:0];
        alpha      = a[W-1:0];
    endtask

    task automatic do_reset();
        RST = 1'b0; clr = 1'b0; upd_valid = 1'b0; b_clr = 1'b0; b_valid = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        for (int k = 0; k < NA; k++) q_model[k] = 0;
        exp_q.delete();
        tick();
    endtask

    // Waits (bounded) for ready, presents one request and returns one cycle after the accept edge.
    task automatic issue(input int act, input longint r, input longint g, input longint a);
        int n = 0;
        while (!upd_ready && n < 20) begin tick(); n++; end
        n_total++;
        if (!upd_ready) $display("FAIL issue_ready: upd_ready=%b required 1", upd_ready);
        else n_pass++;
        drive(act, r, g, a);
        upd_valid = 1'b1;
        model_push(act, r, g, a);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic collect(output int lat);
        int n = 0;
        row_t e;
        while (!done && n < 10) begin tick(); n++; end
        lat = n;
        n_total++;
        if (!done) $display("FAIL collect_timeout: done=%b required 1", done);
        else if (exp_q.size() == 0) $display("FAIL collect_empty: unexpected done");
        else begin
            e = exp_q.pop_front();
            if (q_flat !== e) $display("FAIL q_row: got %h required %h", q_flat, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (q_flat !== '0) $display("FAIL reset_q: got %h required 0", q_flat); else n_pass++;
        n_total++; if (max_q !== '0 || max_idx !== '0) $display("FAIL reset_max: got %h/%0d required 0/0", max_q, max_idx); else n_pass++;
        n_total++; if (upd_ready !== 1'b1 || done !== 1'b0) $display("FAIL reset_ctl: ready=%b done=%b required 1/0", upd_ready, done); else n_pass++;
    endtask

    task automatic test_default();
        int lat;
        do_reset();
        issue(1, 16384, 0, 8192);
        collect(lat);
        n_total++; if (lat != 3) $display("FAIL default_latency: got %0d required 3", lat); else n_pass++;
        n_total++; if (q_flat[W +: W] !== 24'd8192) $display("FAIL default_q1: got %0d required 8192", q_flat[W +: W]); else n_pass++;
        n_total++; if (max_q !== '0) $display("FAIL default_max_early: got %0d required 0", max_q); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL default_done_pulse: got %b required 0", done); else n_pass++;
        n_total++; if (max_q !== 24'd8192 || max_idx !== 2'd1) $display("FAIL default_max: got %0d/%0d required 8192/1", max_q, max_idx); else n_pass++;
    endtask

    task automatic test_ties();
        int lat;
        do_reset();
        issue(2, -16384, 0, 16384); collect(lat); tick();
        n_total++; if (q_flat[2*W +: W] !== 24'hFFC000) $display("FAIL ties_q2: got %h required ffc000", q_flat[2*W +: W]); else n_pass++;
        n_total++; if (max_q !== '0 || max_idx !== 2'd0) $display("FAIL ties_zero: got %0d/%0d required 0/0", max_q, max_idx); else n_pass++;
        issue(3, 16384, 0, 16384); collect(lat); tick();
        n_total++; if (max_q !== 24'd16384 || max_idx !== 2'd3) $display("FAIL ties_q3: got %0d/%0d required 16384/3", max_q, max_idx); else n_pass++;
        issue(1, 16384, 0, 16384); collect(lat); tick();
        n_total++; if (max_q !== 24'd16384 || max_idx !== 2'd1) $display("FAIL ties_lowest: got %0d/%0d required 16384/1", max_q, max_idx); else n_pass++;
    endtask

    task automatic test_overflow();
        int lat;
        logic [W-1:0] want;
`ifdef Q_SAT_EN
        want = 24'h7FFFFF;
`else
        want = 24'h800000;
`endif
        do_reset();
        issue(0, 'h7FFFFF, 1, 16384); collect(lat);
        n_total++; if (q_flat[W-1:0] !== want) $display("FAIL overflow_q0: got %h required %h", q_flat[W-1:0], want); else n_pass++;
    endtask

    task automatic test_abort();
        int lat;
        do_reset();
        issue(1, 16384, 0, 8192); collect(lat); tick();
        issue(1, 16384, 0, 8192);
        tick();
        clr = 1'b1;
        tick();
        for (int k = 0; k < NA; k++) q_model[k] = 0;
        exp_q.delete();
        n_total++; if (q_flat !== '0 || done !== 1'b0) $display("FAIL abort_clear: q=%h done=%b required 0/0", q_flat, done); else n_pass++;
        n_total++; if (upd_ready !== 1'b0) $display("FAIL abort_ready_clr: got %b required 0", upd_ready); else n_pass++;
        clr = 1'b0;
        #1;
        n_total++; if (upd_ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", upd_ready); else n_pass++;
        tick();
        n_total++; if (max_q !== '0 || done !== 1'b0) $display("FAIL abort_max: max=%0d done=%b required 0/0", max_q, done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0 || q_flat !== '0) $display("FAIL abort_nodone: done=%b q=%h required 0/0", done, q_flat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n = 0, lat;
        do_reset();
        drive(0, 16384, 0, 16384);
        model_push(0, 16384, 0, 16384);
        upd_valid = 1'b1;
        tick();
        drive(0, 0, 8192, 8192);
        model_push(0, 0, 8192, 8192);
        while (!upd_ready && n < 10) begin tick(); n++; end
        n_total++; if (n != 3) $display("FAIL b2b_ready_gap: got %0d required 3", n); else n_pass++;
        collect(lat);
        tick();
        n_total++; if (upd_ready !== 1'b0) $display("FAIL b2b_accept_e4: ready=%b required 0", upd_ready); else n_pass++;
        upd_valid = 1'b0;
        collect(lat);
        n_total++; if (lat != 3 || q_flat[W-1:0] !== 24'd12288) $display("FAIL b2b_second: lat=%0d q0=%0d required 3/12288", lat, q_flat[W-1:0]); else n_pass++;
    endtask

    task automatic test_bad_index();
        int n;
        logic [3*W-1:0] want;
        do_reset();
        want = '0;
        want[W +: W] = 24'd8192;
        reward = 24'd16384; gamma_maxq = '0; alpha = 24'd8192;
        b_act = 2'd1; b_valid = 1'b1; tick(); b_valid = 1'b0;
        n = 0; while (!b_done && n < 10) begin tick(); n++; end
        n_total++; if (b_q_flat !== want) $display("FAIL bad_setup: got %h required %h", b_q_flat, want); else n_pass++;
        tick();
        b_act = 2'd3; b_valid = 1'b1; tick(); b_valid = 1'b0;
        n = 0; while (!b_done && n < 10) begin tick(); n++; end
        n_total++; if (b_done !== 1'b1 || n != 3) $display("FAIL bad_done: done=%b lat=%0d required 1/3", b_done, n); else n_pass++;
        n_total++; if (b_q_flat !== want) $display("FAIL bad_nowrite: got %h required %h", b_q_flat, want); else n_pass++;
        tick();
        n_total++; if (b_done !== 1'b0 || b_max_idx !== 2'd1) $display("FAIL bad_after: done=%b idx=%0d required 0/1", b_done, b_max_idx); else n_pass++;
    endtask

    task automatic test_random();
        int lat, act, bi;
        longint r, g, a, v, best;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            act = int'($urandom_range(0, NA-1));
            v = longint'($urandom_range(0, (1 << W) - 1)); r = (v <<< (64-W)) >>> (64-W);
            v = longint'($urandom_range(0, (1 << W) - 1)); g = (v <<< (64-W)) >>> (64-W);
            a = longint'($urandom_range(0, 2 << F));
            issue(act, r, g, a);
            collect(lat);
            tick();
            best = q_model[0]; bi = 0;
            for (int k = 1; k < NA; k++) if (q_model[k] > best) begin best = q_model[k]; bi = k; end
            n_total++;
            if (max_q !== best[W-1:0] || max_idx !== AW'(bi))
                $display("FAIL random_max: got %h/%0d required %h/%0d", max_q, max_idx, best[W-1:0], bi);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_ties();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_bad_index();
        test_random();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/q_row_update.md
Q_ROW_UPDATE -- requirements
Module: q_row_update

Interface
REQ-001 SHALL have parameter W, default 24: data width, signed two's complement fixed point.
REQ-002 SHALL have parameter F, default 14: fractional bits, so 1.0 = 2^F.
REQ-003 SHALL have parameter NUM_ACT, default 4: actions per row, range 2..16; AW = max(1, clog2(NUM_ACT)), derived.
REQ-004 Clock and reset ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
REQ-005 Control ports:
- clr  in  1  synchronous clear of the whole row.
- upd_valid  in  1  update request.
- upd_ready  out  1  block can accept an update.
- upd_act  in  AW  action index to update.
REQ-006 Data input ports, each W bits:
- reward  in  W  reward r.
- gamma_maxq  in  W  gamma * max Q of the next state.
- alpha  in  W  learning rate.
REQ-007 Output ports:
- q_flat  out  NUM_ACT*W  stored Q values; action k occupies bits [k*W +: W].
- max_q  out  W  largest stored Q.
- max_idx  out  AW  index of the largest stored Q.
- done  out  1  one-cycle pulse when an update completes.

Function
REQ-008 The FSM SHALL have four states: IDLE, DIFF, MUL, WB. upd_ready = (state==IDLE) and !clr.
REQ-009 Accept edge E0, when upd_valid && upd_ready:
- capture upd_act, reward, gamma_maxq and alpha;
- go to DIFF.
REQ-010 Holding upd_valid while upd_ready is low SHALL have no effect.
REQ-011 DIFF, registered at E1: d = reward + gamma_maxq - Q[act].
- Computed in W+2 bits.
- Reduced to W bits per REQ-020.
- Go to MUL.
REQ-012 MUL, registered at E2: p = (alpha*d) >>> F.
- Full 2W-bit signed product.
- Arithmetic shift right, truncating toward minus infinity.
- Reduced to W bits; go to WB.
REQ-013 WB at E3: Q[act] <= Q[act] + p, reduced to W bits.
- done is high in the cycle following E3.
- Return to IDLE.
- Earliest next accept is E4.
REQ-014 Q[act] used in DIFF and WB SHALL be the stored value; no other entry changes while an update is in flight.
REQ-015 upd_act >= NUM_ACT SHALL be accepted and SHALL run the full sequence with no Q write; done still pulses.
REQ-016 max_q/max_idx are registered, recomputed every cycle from stored Q.
- They reflect a write at E3 from E4 on.
- Ties resolve to the lowest index.
REQ-017 clr has priority over everything:
- all Q entries become 0 at that edge;
- any in-flight update is aborted with no write and no done;
- the FSM goes to IDLE.
REQ-018 q_flat SHALL be driven directly from the Q registers, with no extra latency.

Reset
REQ-019 While RST is low, the following SHALL hold:
- Q entries, d and p are 0;
- the FSM is in IDLE;
- done = 0, max_q = 0, max_idx = 0;
- upd_ready = 1 after release, unless clr is high.
A reset mid-update discards the update.

Configuration
REQ-020 Macro Q_SAT_EN controls W-bit reduction of d, p and the new Q:
- Defined: results saturate to [-2^(W-1), 2^(W-1)-1].
- Undefined: results wrap modulo 2^W (low W bits kept).

Verification
REQ-021 Defaults, after reset: Q all 0 -> max_q=0, max_idx=0, upd_ready=1.
- Accept act=1, reward=16384, gamma_maxq=0, alpha=8192 at E0.
- Expected: Q[1]=8192 at E3, done pulse after E3, max_idx=1 and max_q=8192 from E4.
REQ-022 Ties: from reset, update act=2 with reward=-16384, gamma_maxq=0, alpha=16384.
- Expected: Q[2]=-16384, max_idx=0, max_q=0.
- Then update act=3 with reward=16384. Expected: max_idx=3, max_q=16384.
REQ-023 Overflow: reward=0x7FFFFF, gamma_maxq=1, alpha=16384, Q[0]=0, act=0.
- With Q_SAT_EN: Q[0]=0x7FFFFF.
- Without Q_SAT_EN: Q[0]=0x800000.
REQ-024 Abort: clr asserted in MUL state.
- Expected: all Q=0 next edge, no done pulse, IDLE, upd_ready=1 once clr drops.
- max_q=0 one cycle later.
REQ-025 Back-to-back and bad index:
- upd_valid held high for two updates. Expected: the second is accepted exactly at E4.
- With NUM_ACT=3, upd_act=3. Expected: done pulses and all Q are unchanged.
